// File: rtl/pool_3d_stream.sv
// Streaming multi-channel POOLxPOOL pooling (average, or max when POOL3D_MAX_EN is defined).
// Without POOL3D_MAX_EN the comparators are not built and the mode input is ignored.
module pool_3d_stream #(
    parameter int CHANNELS = 6,
    parameter int IN_DIM   = 28,
    parameter int POOL     = 2,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         frame_done,
    output logic                         busy
);
    localparam int LP = $clog2(POOL);
    localparam int SW = DATA_W + 2*LP;
    localparam int NW = IN_DIM / POOL;
    localparam int CW = $clog2(IN_DIM);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    generate
        if (IN_DIM % POOL != 0) begin : g_bad_dim
            $error("IN_DIM must be a multiple of POOL");
        end
        if (POOL < 2 || POOL > 8 || (POOL & (POOL - 1)) != 0) begin : g_bad_pool
            $error("POOL must be a power of two in 2..8");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [CW-1:0]                r_col;
    logic [CW-1:0]                r_row;
    logic                         r_out_valid;
    logic                         r_frame_done;
    logic [CHANNELS*DATA_W-1:0]   r_out_data;
    logic [CHANNELS*DATA_W-1:0]   w_res;
    logic                         w_acc;
    logic                         w_hfirst;
    logic                         w_hlast;
    logic                         w_vfirst;
    logic                         w_vlast;
    logic                         w_win;
    logic                         w_last;
    logic [IW-1:0]                w_idx;

    // A start in the same cycle as a beat takes priority; that beat is dropped.
    assign w_acc    = (r_state == S_RUN) && in_valid && !start;
    assign w_hfirst = (r_col[LP-1:0] == '0);
    assign w_hlast  = &r_col[LP-1:0];
    assign w_vfirst = (r_row[LP-1:0] == '0);
    assign w_vlast  = &r_row[LP-1:0];
    assign w_win    = w_acc && w_hlast && w_vlast;
    assign w_last   = (r_col == CW'(IN_DIM - 1)) && (r_row == CW'(IN_DIM - 1));
    assign w_idx    = IW'(r_col >> LP);

`ifdef POOL3D_MAX_EN
    logic r_mode;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
        end else if (start) begin
            r_mode <= mode;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
`endif

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            logic signed [DATA_W-1:0] w_in;
            logic signed [SW-1:0]     w_x;
            logic signed [SW-1:0]     w_h;
            logic signed [SW-1:0]     w_v;
            logic signed [SW-1:0]     w_lb;
            logic signed [DATA_W-1:0] w_sh;
            logic signed [SW-1:0]     r_hacc;
            logic signed [SW-1:0]     r_lb [NW];

            assign w_in = in_data[c*DATA_W +: DATA_W];
            assign w_x  = SW'(w_in);
            assign w_lb = r_lb[w_idx];
            assign w_sh = DATA_W'(w_v >>> (2*LP));
`ifdef POOL3D_MAX_EN
            logic signed [SW-1:0] w_hmax;
            logic signed [SW-1:0] w_vmax;
            assign w_hmax = (r_hacc > w_x) ? r_hacc : w_x;
            assign w_vmax = (w_lb > w_h) ? w_lb : w_h;
            assign w_h = w_hfirst ? w_x :
                         (r_mode ? w_hmax : r_hacc + w_x);
            assign w_v = w_vfirst ? w_h :
                         (r_mode ? w_vmax : w_lb + w_h);
            assign w_res[c*DATA_W +: DATA_W] =
                r_mode ? w_v[DATA_W-1:0] : w_sh;
`else
            assign w_h = w_hfirst ? w_x : r_hacc + w_x;
            assign w_v = w_vfirst ? w_h : w_lb + w_h;
            assign w_res[c*DATA_W +: DATA_W] = w_sh;
`endif
            // First row of a band overwrites its entry, so aborted partials never leak.
            always_ff @(posedge clk) begin
                if (w_acc) begin
                    r_hacc <= w_h;
                    if (w_hlast) begin
                        r_lb[w_idx] <= w_v;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else if (w_acc && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_out_valid  <= w_win;
            r_frame_done <= w_win && w_last;
            if (w_win) begin
                r_out_data <= w_res;
            end
            if (start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_acc) begin
                if (r_col == CW'(IN_DIM - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == CW'(IN_DIM - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == S_RUN);

endmodule

// File: tb/tb_pool_3d_stream.sv
// Directed bench for pool_3d_stream: 2 channels, 4x4 frames, 2x2 windows.
// Max-mode expectations depend on whether POOL3D_MAX_EN is defined.
module tb_pool_3d_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic [63:0] out_data;
    logic        frame_done;
    logic        busy;

    pool_3d_stream #(
        .CHANNELS(2), .IN_DIM(4), .POOL(2), .DATA_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int q0[$], q1[$], qc[$], qe[$];
    bit qfd[$], qbusy[$];
    int exp0[4], exp1[4];

    always @(negedge clk) begin
        if (out_valid) begin
            q0.push_back(int'(out_data[31:0]));
            q1.push_back(int'(out_data[63:32]));
            qc.push_back(cyc);
            qfd.push_back(frame_done);
            qbusy.push_back(busy);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int pix(input int pat, input int ch, input int i);
        case (pat)
            0: return (ch == 0) ? i : -3;
            1: return 8;
            2: begin
                if (ch == 0) return (i == 0) ? -1 : 0;
                return (i == 0 || i == 1 || i == 4) ? 1 : 0;
            end
            default: return 100;
        endcase
    endfunction

    task automatic clr();
        q0.delete(); q1.delete(); qc.delete();
        qe.delete(); qfd.delete(); qbusy.delete();
    endtask

    task automatic go(input bit md);
        mode = md;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'b0;
    endtask

    task automatic feed(input int pat, input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            in_data = {32'(pix(pat, 1, i)), 32'(pix(pat, 0, i))};
            in_valid = 1'b1;
            @(posedge clk); #1;
            if ((i % 2 == 1) && ((i / 4) % 2 == 1)) qe.push_back(cyc);
            in_valid = 1'b0;
            in_data = '0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".count"}, q0.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < q0.size()) begin
                chk($sformatf("%s.ch0[%0d]", tag, k), q0[k], exp0[k]);
                chk($sformatf("%s.ch1[%0d]", tag, k), q1[k], exp1[k]);
                if (k < qe.size())
                    chk($sformatf("%s.lat[%0d]", tag, k), qc[k], qe[k]);
                chk($sformatf("%s.fd[%0d]", tag, k), qfd[k], (k == 3) ? 1 : 0);
                chk($sformatf("%s.busy[%0d]", tag, k), qbusy[k], (k == 3) ? 0 : 1);
            end
        end
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.busy", busy, 0);
        chk("rst.frame_done", frame_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        clr(); go(0); feed(0, 16, 0);
        exp0 = '{2, 4, 10, 12};
        exp1 = '{-3, -3, -3, -3};
        chk("avg.busy_run", busy, 0);
        check_frame("avg");

        clr(); go(1); feed(0, 16, 0);
`ifdef POOL3D_MAX_EN
        exp0 = '{5, 7, 13, 15};
`else
        exp0 = '{2, 4, 10, 12};
`endif
        check_frame("max");

        clr(); go(0); feed(2, 16, 0);
        exp0 = '{-1, 0, 0, 0};
        exp1 = '{0, 0, 0, 0};
        check_frame("rnd");

        clr(); go(0); feed(0, 16, 1);
        exp0 = '{2, 4, 10, 12};
        exp1 = '{-3, -3, -3, -3};
        check_frame("gap");

        go(0); feed(3, 9, 0);
        repeat (2) @(posedge clk);
        #1;
        clr(); go(0); feed(1, 16, 0);
        exp0 = '{8, 8, 8, 8};
        exp1 = '{8, 8, 8, 8};
        check_frame("abort");

        go(0); feed(0, 6, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst.out_valid", out_valid, 0);
        chk("mrst.out_data", out_data, 0);
        chk("mrst.busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clr(); go(0); feed(0, 16, 0);
        exp0 = '{2, 4, 10, 12};
        exp1 = '{-3, -3, -3, -3};
        check_frame("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
